// File: rtl/seq_feed_ctrl.sv
// seq_feed_ctrl: shifts a latched pattern LSB-first into a 10001 detector and records hit count and last hit position
module seq_feed_ctrl #(
    parameter int WIDTH = 16,
    parameter int IDXW  = 5,
    parameter int CNTW  = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] pat,
    input  logic [IDXW-1:0]  len,
    output logic             busy,
    output logic             done,
    output logic             det_clr,
    output logic             det_din,
    input  logic             det_dout,
    output logic [CNTW-1:0]  hit_cnt,
    output logic [IDXW-1:0]  hit_pos
);
    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;
    state_t state, nxt;
    logic [WIDTH-1:0] pat_r, pat_sh;
    logic [IDXW-1:0] len_r, len_c, idx;
    logic go, sample;
    assign len_c = ({1'b0, len} > (IDXW+1)'(WIDTH)) ? IDXW'(WIDTH) : len;
    assign go = state == IDLE && start;
    assign pat_sh = pat_r >> idx;
    // detector output lags one cycle, so the sample at idx refers to bit idx-1
    assign sample = det_dout && ((state == SHIFT && idx != '0) || state == DRAIN);
    always_comb begin
        nxt = state;
        busy = state != IDLE;
        done = state == DONE;
        det_clr = state == IDLE || state == CLEAR;
        det_din = state == SHIFT && pat_sh[0];
        case (state)
            IDLE:    nxt = !start ? IDLE : (len_c == '0 ? DONE : CLEAR);
            CLEAR:   nxt = SHIFT;
            SHIFT:   nxt = (idx == len_r - 1'b1) ? DRAIN : SHIFT;
            DRAIN:   nxt = DONE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge clr)
        if (!clr) state <= IDLE;
        else state <= nxt;
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pat_r <= '0;
            len_r <= '0;
            idx <= '0;
            hit_cnt <= '0;
            hit_pos <= '0;
        end else begin
            if (go && len_c != '0) begin
                pat_r <= pat;
                len_r <= len_c;
            end
            if ((go && len_c == '0) || state == CLEAR) begin
                hit_cnt <= '0;
                hit_pos <= '0;
            end else if (sample) begin
                hit_cnt <= &hit_cnt ? hit_cnt : hit_cnt + 1'b1;
                hit_pos <= idx - 1'b1;
            end
            idx <= state == CLEAR ? '0 : state == SHIFT ? idx + 1'b1 : idx;
        end
    end
endmodule

// File: tb/tb_seq_feed_ctrl.sv
// tb_seq_feed_ctrl: table-driven check of seq_feed_ctrl with a behavioural 10001 detector plus a stub-driven saturating instance
module tb_seq_feed_ctrl;
    logic clk = 0, clr = 0, start = 0;
    logic [15:0] pat = '0;
    logic [4:0] len = '0;
    logic busy, done, det_clr, det_din, det_dout;
    logic [4:0] hit_cnt, hit_pos;
    logic sat_start = 0, sat_dout = 0;
    logic sat_busy, sat_done, sat_clr, sat_din;
    logic [1:0] sat_cnt;
    logic [4:0] sat_pos;
    logic [4:0] hist;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    seq_feed_ctrl #(.WIDTH(16), .IDXW(5), .CNTW(5)) dut (
        .clk(clk), .clr(clr), .start(start), .pat(pat), .len(len),
        .busy(busy), .done(done), .det_clr(det_clr), .det_din(det_din),
        .det_dout(det_dout), .hit_cnt(hit_cnt), .hit_pos(hit_pos));

    seq_feed_ctrl #(.WIDTH(16), .IDXW(5), .CNTW(2)) u_sat (
        .clk(clk), .clr(clr), .start(sat_start), .pat(16'h1111), .len(5'd16),
        .busy(sat_busy), .done(sat_done), .det_clr(sat_clr), .det_din(sat_din),
        .det_dout(sat_dout), .hit_cnt(sat_cnt), .hit_pos(sat_pos));

    // overlapping Moore 10001 detector: output depends only on the last five received bits
    always_ff @(posedge clk or negedge clr)
        if (!clr) hist <= '0;
        else if (det_clr) hist <= '0;
        else hist <= {hist[3:0], det_din};
    assign det_dout = hist == 5'b10001;

    typedef struct {
        logic [15:0] pat;
        logic [4:0]  len;
        logic [4:0]  cnt;
        logic [4:0]  pos;
        int          lat;
        int          bsy;
        logic [31:0] bits;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string nm, input int v, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %0h, expected %0h", nm, v, act, exp);
        end
    endtask

    task automatic run_vec(input int v);
        int k, np, nb;
        logic [31:0] cap;
        bit seen;
        @(negedge clk);
        pat = vt[v].pat;
        len = vt[v].len;
        start = 1;
        @(negedge clk);
        start = 0;
        pat = 16'hA5A5;
        len = 5'd7;
        k = 1; np = 0; nb = 0; cap = '0; seen = 0;
        while (!seen && k <= 40) begin
            if (busy) nb++;
            if (!det_clr && !done && np < 32) begin
                cap[np] = det_din;
                np++;
            end
            if (done) seen = 1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        chk("done_cycle", v, seen ? k : 32'hFFFF, vt[v].lat);
        chk("busy_cycles", v, nb, vt[v].bsy);
        chk("din_bits", v, cap, vt[v].bits);
        chk("hit_cnt", v, hit_cnt, vt[v].cnt);
        chk("hit_pos", v, hit_pos, vt[v].pos);
        @(negedge clk);
        chk("idle_after_done", v, {busy, done, det_clr}, 3'b001);
    endtask

    initial begin
        vt[0] = '{16'h0011, 5'd5,  5'd1, 5'd4,  8,  8,  32'h0011};
        vt[1] = '{16'h0111, 5'd9,  5'd2, 5'd8,  12, 12, 32'h0111};
        vt[2] = '{16'hFFFF, 5'd0,  5'd0, 5'd0,  1,  1,  32'h0};
        vt[3] = '{16'h0000, 5'd31, 5'd0, 5'd0,  19, 19, 32'h0};
        vt[4] = '{16'h1111, 5'd16, 5'd3, 5'd12, 19, 19, 32'h1111};
        vt[5] = '{16'h1111, 5'd20, 5'd3, 5'd12, 19, 19, 32'h1111};
        vt[6] = '{16'h0011, 5'd4,  5'd0, 5'd0,  7,  7,  32'h0001};
        vt[7] = '{16'h0001, 5'd1,  5'd0, 5'd0,  4,  4,  32'h0001};

        repeat (3) @(negedge clk);
        chk("rst_busy", -1, busy, 1'b0);
        chk("rst_done", -1, done, 1'b0);
        chk("rst_det_clr", -1, det_clr, 1'b1);
        chk("rst_det_din", -1, det_din, 1'b0);
        chk("rst_hit_cnt", -1, hit_cnt, 5'd0);
        chk("rst_hit_pos", -1, hit_pos, 5'd0);
        chk("rst_sat_cnt", -1, sat_cnt, 2'd0);
        clr = 1;

        for (int v = 0; v < 8; v++) run_vec(v);

        // start during SHIFT is ignored, then reset mid-run returns to IDLE at once
        @(negedge clk);
        pat = 16'h0011; len = 5'd5; start = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        start = 1; pat = 16'hFFFF; len = 5'd0;
        @(negedge clk);
        start = 0;
        chk("busy_ignore_busy", 8, busy, 1'b1);
        chk("busy_ignore_done", 8, done, 1'b0);
        chk("busy_ignore_clr", 8, det_clr, 1'b0);
        chk("busy_ignore_din", 8, det_din, 1'b0);
        clr = 0;
        #1;
        chk("async_busy", 8, busy, 1'b0);
        chk("async_det_clr", 8, det_clr, 1'b1);
        chk("async_hit_cnt", 8, hit_cnt, 5'd0);
        begin
            bit any_done;
            any_done = done;
            repeat (3) begin
                @(negedge clk);
                any_done |= done;
            end
            chk("async_no_done", 8, any_done, 1'b0);
        end
        clr = 1;
        run_vec(0);

        // saturation with a stub detector on a 2-bit counter instance
        @(negedge clk);
        sat_start = 1;
        sat_dout = 1;
        @(negedge clk);
        sat_start = 0;
        for (int k = 1; k <= 19; k++) begin
            sat_dout = (k == 1 || k == 2 || k == 6 || k == 9 || k == 12 || k == 17 || k == 19);
            if (k == 7) begin
                chk("sat_first_cnt", 9, sat_cnt, 2'd1);
                chk("sat_first_pos", 9, sat_pos, 5'd3);
            end
            if (k == 13) chk("sat_three_pos", 9, sat_pos, 5'd9);
            if (k == 19) chk("sat_done", 9, sat_done, 1'b1);
            if (k < 19) @(negedge clk);
        end
        @(negedge clk);
        sat_dout = 0;
        chk("sat_cnt", 9, sat_cnt, 2'd3);
        chk("sat_pos", 9, sat_pos, 5'd14);
        chk("sat_idle", 9, sat_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
